// File: rtl/shared_ram_responder.sv
`default_nettype none
// ============================================================================
// Module   : shared_ram_responder
// Brief    : Single-port RAM shared by the instruction-fetch (pc_*) and the
//            operand load/store (op_*) masters. Round-robin arbitration on
//            ties, req/ack handshake, WAIT_STATES extra cycles per access.
//            Optional build macro RAM_CLEAR_ON_RESET_EN: memory words are
//            cleared asynchronously by reset_n; otherwise contents survive
//            reset.
// Revision : 1.0 - initial release
// ============================================================================
module shared_ram_responder #(
    parameter int WORD_WIDTH  = 8,
    parameter int ADDR_WIDTH  = 3,
    parameter int WAIT_STATES = 1
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  pc_req,
    input  logic [ADDR_WIDTH-1:0] pc_addr,
    output logic [WORD_WIDTH-1:0] pc_rdata,
    output logic                  pc_ack,
    input  logic                  op_req,
    input  logic                  op_write,
    input  logic [ADDR_WIDTH-1:0] op_addr,
    input  logic [WORD_WIDTH-1:0] op_wdata,
    output logic [WORD_WIDTH-1:0] op_rdata,
    output logic                  op_ack,
    output logic                  busy
);

    localparam int c_depth   = 2 ** ADDR_WIDTH;
    localparam int c_cnt_w   = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
    localparam bit c_no_wait = (WAIT_STATES == 0);
    localparam logic [c_cnt_w-1:0] c_last_cnt =
        c_cnt_w'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2
    } state_t;

    state_t                  r_state;
    logic [c_cnt_w-1:0]      r_cnt;
    logic                    r_last_pc;   // 1: last tie went to PC
    logic                    r_sel_pc;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic                    r_write;
    logic [WORD_WIDTH-1:0]   r_wdata;
    logic [WORD_WIDTH-1:0]   r_pc_rdata;
    logic [WORD_WIDTH-1:0]   r_op_rdata;
    logic                    r_pc_ack;
    logic                    r_op_ack;
    logic                    r_busy;
    logic [WORD_WIDTH-1:0]   r_mem [c_depth];

    logic                    w_any_req;
    logic                    w_tie;
    logic                    w_pick_pc;
    logic [ADDR_WIDTH-1:0]   w_in_addr;
    logic                    w_in_write;
    logic                    w_in_idle;
    logic                    w_cur_sel_pc;
    logic [ADDR_WIDTH-1:0]   w_cur_addr;
    logic                    w_cur_write;
    logic [WORD_WIDTH-1:0]   w_cur_wdata;
    logic                    w_enter_ack;

    // Arbitration and selection of the access that completes on this edge.
    // With no wait states the access commits on the grant edge itself, so
    // the live request fields are used instead of the latched copies.
    always_comb begin
        w_any_req    = pc_req || op_req;
        w_tie        = pc_req && op_req;
        w_pick_pc    = pc_req && (!op_req || !r_last_pc);
        w_in_addr    = w_pick_pc ? pc_addr : op_addr;
        w_in_write   = w_pick_pc ? 1'b0 : op_write;
        w_in_idle    = (r_state == S_IDLE);
        w_cur_sel_pc = w_in_idle ? w_pick_pc  : r_sel_pc;
        w_cur_addr   = w_in_idle ? w_in_addr  : r_addr;
        w_cur_write  = w_in_idle ? w_in_write : r_write;
        w_cur_wdata  = w_in_idle ? op_wdata   : r_wdata;
        w_enter_ack  = (w_in_idle && w_any_req && c_no_wait) ||
                       ((r_state == S_WAIT) && (r_cnt == c_last_cnt));
    end

    // Access FSM with registered ack, read data and busy outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_last_pc  <= 1'b0;
            r_sel_pc   <= 1'b0;
            r_addr     <= '0;
            r_write    <= 1'b0;
            r_wdata    <= '0;
            r_pc_rdata <= '0;
            r_op_rdata <= '0;
            r_pc_ack   <= 1'b0;
            r_op_ack   <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            r_pc_ack <= 1'b0;
            r_op_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any_req) begin
                        r_sel_pc <= w_pick_pc;
                        r_addr   <= w_in_addr;
                        r_write  <= w_in_write;
                        r_wdata  <= op_wdata;
                        r_cnt    <= '0;
                        r_busy   <= 1'b1;
                        // Only contested grants move the round-robin pointer.
                        if (w_tie) begin
                            r_last_pc <= w_pick_pc;
                        end
                        r_state <= c_no_wait ? S_ACK : S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (r_cnt == c_last_cnt) begin
                        r_state <= S_ACK;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_ACK: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
            if (w_enter_ack) begin
                if (w_cur_sel_pc) begin
                    r_pc_ack <= 1'b1;
                    if (!w_cur_write) begin
                        r_pc_rdata <= r_mem[w_cur_addr];
                    end
                end else begin
                    r_op_ack <= 1'b1;
                    if (!w_cur_write) begin
                        r_op_rdata <= r_mem[w_cur_addr];
                    end
                end
            end
        end
    end

`ifdef RAM_CLEAR_ON_RESET_EN
    // Storage array, cleared together with the rest of the state on reset.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < c_depth; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_enter_ack && w_cur_write) begin
            r_mem[w_cur_addr] <= w_cur_wdata;
        end
    end
`else
    // Storage array; contents persist across reset, writes blocked while
    // reset is held so an aborted access can never commit.
    always_ff @(posedge clk) begin
        if (reset_n && w_enter_ack && w_cur_write) begin
            r_mem[w_cur_addr] <= w_cur_wdata;
        end
    end
`endif

    assign pc_rdata = r_pc_rdata;
    assign op_rdata = r_op_rdata;
    assign pc_ack   = r_pc_ack;
    assign op_ack   = r_op_ack;
    assign busy     = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_shared_ram_responder.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_shared_ram_responder
// Brief    : Directed self-checking bench; expected grants and read data are
//            queued when stimulus is driven and popped on each ack.
// Revision : 1.0 - initial release
// ============================================================================
module tb_shared_ram_responder;

    localparam int WS = 1;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       pc_req, op_req, op_write;
    logic [2:0] pc_addr, op_addr;
    logic [7:0] op_wdata, pc_rdata, op_rdata;
    logic       pc_ack, op_ack, busy;

    logic       z_pc_req, z_op_req, z_op_write;
    logic [2:0] z_pc_addr, z_op_addr;
    logic [7:0] z_op_wdata, z_pc_rdata, z_op_rdata;
    logic       z_pc_ack, z_op_ack, z_busy;

    always #5 clk = ~clk;

    shared_ram_responder #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(WS)) dut (
        .clk(clk), .reset_n(reset_n),
        .pc_req(pc_req), .pc_addr(pc_addr), .pc_rdata(pc_rdata), .pc_ack(pc_ack),
        .op_req(op_req), .op_write(op_write), .op_addr(op_addr), .op_wdata(op_wdata),
        .op_rdata(op_rdata), .op_ack(op_ack), .busy(busy)
    );

    shared_ram_responder #(.WORD_WIDTH(8), .ADDR_WIDTH(3), .WAIT_STATES(0)) dut0 (
        .clk(clk), .reset_n(reset_n),
        .pc_req(z_pc_req), .pc_addr(z_pc_addr), .pc_rdata(z_pc_rdata), .pc_ack(z_pc_ack),
        .op_req(z_op_req), .op_write(z_op_write), .op_addr(z_op_addr), .op_wdata(z_op_wdata),
        .op_rdata(z_op_rdata), .op_ack(z_op_ack), .busy(z_busy)
    );

    typedef struct {
        bit         is_pc;
        bit         chk;
        logic [7:0] data;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] model   [8];
    logic [7:0] z_model [4];
    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic void push(input bit p, input bit c, input logic [7:0] d);
        exp_t e;
        e.is_pc = p;
        e.chk   = c;
        e.data  = d;
        sb.push_back(e);
    endfunction

    // Scoreboard: every ack must match the next queued grant.
    always @(negedge clk) begin : mon
        exp_t e;
        if (reset_n && (pc_ack || op_ack)) begin
            check("ack_exclusive", pc_ack & op_ack, 0);
            check("sb_nonempty", sb.size() != 0, 1);
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("grant_port", pc_ack, e.is_pc);
                if (e.chk) begin
                    check(e.is_pc ? "pc_rdata" : "op_rdata", e.is_pc ? pc_rdata : op_rdata, e.data);
                end
            end
        end
    end

    // Raise the selected requests together, drop each on its ack.
    task automatic run_access(input bit use_pc, input bit use_op, input logic [2:0] pa,
                              input bit ow, input logic [2:0] oa, input logic [7:0] od,
                              output int pl, output int ol);
        bit pp, opd;
        pl = -1; ol = -1;
        pp = use_pc; opd = use_op;
        pc_req = use_pc; pc_addr = pa;
        op_req = use_op; op_write = ow; op_addr = oa; op_wdata = od;
        for (int n = 1; n <= 40 && (pp || opd); n++) begin
            @(negedge clk);
            if (pc_ack && pp) begin pl = n; pp = 0; pc_req = 1'b0; end
            if (op_ack && opd) begin ol = n; opd = 0; op_req = 1'b0; end
        end
        pc_req = 1'b0; op_req = 1'b0;
        check("timeout", {pp, opd}, 0);
        @(negedge clk);
    endtask

    task automatic z_op(input bit w, input logic [2:0] a, input logic [7:0] d, output int lat);
        lat = -1;
        z_op_req = 1'b1; z_op_write = w; z_op_addr = a; z_op_wdata = d;
        for (int n = 1; n <= 20 && lat < 0; n++) begin
            @(negedge clk);
            if (z_op_ack) lat = n;
        end
        z_op_req = 1'b0;
        check("z_timeout", lat > 0, 1);
        @(negedge clk);
    endtask

    initial begin : stim
        int pl, ol, n, nacks, first, last_n, idle, prev;
        logic [7:0] expv;
        bit seen;
        reset_n = 1'b0;
        pc_req = 0; pc_addr = 0; op_req = 0; op_write = 0; op_addr = 0; op_wdata = 0;
        z_pc_req = 0; z_pc_addr = 0; z_op_req = 0; z_op_write = 0; z_op_addr = 0; z_op_wdata = 0;
        repeat (2) @(negedge clk);
        check("rst_pc_ack", pc_ack, 0);
        check("rst_op_ack", op_ack, 0);
        check("rst_busy", busy, 0);
        check("rst_pc_rdata", pc_rdata, 0);
        check("rst_op_rdata", op_rdata, 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Fill memory through the op port.
        for (int i = 0; i < 8; i++) begin
            model[i] = 8'(32'h20 + i * 7);
            push(0, 0, 8'h00);
            run_access(0, 1, 3'd0, 1'b1, 3'(i), model[i], pl, ol);
        end

        // Write then read back through the other port, with latency.
        model[3] = 8'hA5;
        push(0, 0, 8'h00);
        run_access(0, 1, 3'd0, 1'b1, 3'd3, 8'hA5, pl, ol);
        check("op_write_lat", ol, WS + 1);
        push(1, 1, 8'hA5);
        run_access(1, 0, 3'd3, 1'b0, 3'd0, 8'h00, pl, ol);
        check("pc_read_lat", pl, WS + 1);

        // First tie after reset goes to PC.
        push(1, 1, model[1]);
        push(0, 1, model[4]);
        run_access(1, 1, 3'd1, 1'b0, 3'd4, 8'h00, pl, ol);
        check("tie1_pc_lat", pl, WS + 1);
        check("tie1_op_lat", ol, 2 * WS + 3);
        check("pc_rdata_hold", pc_rdata, model[1]);

        // Next tie goes to OP.
        push(0, 1, model[6]);
        push(1, 1, model[0]);
        run_access(1, 1, 3'd0, 1'b0, 3'd6, 8'h00, pl, ol);
        check("tie2_op_lat", ol, WS + 1);
        check("tie2_pc_lat", pl, 2 * WS + 3);

        // Both ports held: strict alternation, one idle cycle between accesses.
        for (int k = 0; k < 4; k++) begin
            push(1, 1, model[k]);
            push(0, 1, model[4 + k]);
        end
        pc_req = 1; pc_addr = 3'd0; op_req = 1; op_write = 0; op_addr = 3'd4;
        n = 0; nacks = 0; first = -1; last_n = -1; idle = 0;
        while (nacks < 8 && n < 100) begin
            @(negedge clk);
            n++;
            if (first >= 0 && !busy) idle++;
            if (pc_ack) begin
                nacks++; last_n = n;
                if (first < 0) first = n;
                if (pc_addr == 3'd3) pc_req = 1'b0; else pc_addr = pc_addr + 3'd1;
            end
            if (op_ack) begin
                nacks++; last_n = n;
                if (first < 0) first = n;
                if (op_addr == 3'd7) op_req = 1'b0; else op_addr = op_addr + 3'd1;
            end
        end
        pc_req = 0; op_req = 0;
        check("alt_acks", nacks, 8);
        check("alt_span", last_n - first, 7 * (WS + 2));
        check("alt_idle", idle, 7);
        @(negedge clk);

        // Back-to-back read-after-write across ports (tie goes to OP here).
        model[6] = 8'h5A;
        push(0, 0, 8'h00);
        push(1, 1, 8'h5A);
        run_access(1, 1, 3'd6, 1'b1, 3'd6, 8'h5A, pl, ol);
        check("raw_op_lat", ol, WS + 1);
        check("raw_pc_lat", pl, 2 * WS + 3);
        check("op_rdata_hold", op_rdata, model[7]);

        // Request withdrawn mid-access: access still completes.
        model[1] = 8'h77;
        push(0, 0, 8'h00);
        op_req = 1; op_write = 1; op_addr = 3'd1; op_wdata = 8'h77;
        @(negedge clk);
        op_req = 0;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            if (op_ack) seen = 1;
        end
        check("withdraw_ack", seen, 1);
        @(negedge clk);
        push(1, 1, 8'h77);
        run_access(1, 0, 3'd1, 1'b0, 3'd0, 8'h00, pl, ol);

        // Reset during WAIT drops the write and clears outputs at once.
        model[2] = 8'h11;
        push(0, 0, 8'h00);
        run_access(0, 1, 3'd0, 1'b1, 3'd2, 8'h11, pl, ol);
        model[5] = 8'hC3;
        push(0, 0, 8'h00);
        run_access(0, 1, 3'd0, 1'b1, 3'd5, 8'hC3, pl, ol);
        op_req = 1; op_write = 1; op_addr = 3'd5; op_wdata = 8'h3C;
        @(negedge clk);
        check("busy_in_wait", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_pc_rdata", pc_rdata, 0);
        check("rst_mid_op_rdata", op_rdata, 0);
        op_req = 0;
        seen = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (op_ack) seen = 1;
        end
        check("rst_no_ack", seen, 0);
        reset_n = 1'b1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
`ifdef RAM_CLEAR_ON_RESET_EN
            expv = 8'h00;
`else
            expv = model[i];
`endif
            push(1, 1, expv);
            run_access(1, 0, 3'(i), 1'b0, 3'd0, 8'h00, pl, ol);
        end

        // Zero wait states: held read with address stepping on each ack.
        for (int i = 0; i < 4; i++) begin
            z_model[i] = 8'(32'h90 + i * 13);
            z_op(1'b1, 3'(i), z_model[i], pl);
        end
        check("z_write_lat", pl, 1);
        z_op_req = 1; z_op_write = 0; z_op_addr = 3'd0;
        nacks = 0; prev = 0; n = 0;
        while (nacks < 4 && n < 40) begin
            @(negedge clk);
            n++;
            if (z_op_ack) begin
                check("z_rdata", z_op_rdata, z_model[nacks]);
                check("z_ack_spacing", n - prev, (nacks == 0) ? 1 : 2);
                prev = n;
                nacks++;
                if (z_op_addr == 3'd3) z_op_req = 1'b0; else z_op_addr = z_op_addr + 3'd1;
            end
        end
        z_op_req = 0;
        check("z_acks", nacks, 4);
        @(negedge clk);

        check("sb_drained", sb.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
